writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Shares the single register-file write port between two writeback sources. Source A is execute/ALU results: fixed latency, high priority, unbuffered. Source B is load/CSR results: variable latency, buffered in a small FIFO. The block drives the register file's active-low write enable, address and data from registered outputs. It adds a starvation guard so that B cannot be blocked indefinitely. It also exports a pending-write mask that the core's hazard logic uses to stall issue.

## Interface
- DEPTH, 2, B-side FIFO entries; power of two, ≥2.
- MAX_WAIT, 4, cycles the B FIFO head may wait before it is forced to win arbitration; ≥1.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- a_valid  in  1  A has a result this cycle.
- a_ready  out  1  A result is accepted at this rising edge.
- a_addr  in  5  A destination register.
- a_data  in  32  A result.
- b_valid  in  1  B has a result.
- b_ready  out  1  FIFO not full.
- b_addr  in  5  B destination register.
- b_data  in  32  B result.
- rf_write_enable  out  1  active-low write enable to the register file.
- rf_write_addr  out  5  registered write address.
- rf_write_data  out  32  registered write data.
- busy_mask  out  32  bit r = 1 when any FIFO entry targets register r (r≠0).

## Operation
- **FIFO:** b_valid && b_ready pushes {b_addr, b_data} into a DEPTH-entry circular FIFO with wrapping read/write pointers and an occupancy count.
- **b_ready:** equals !full, purely from registered state. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- **Starve counter:** width clog2(MAX_WAIT+1).
  - Increments each cycle the FIFO is non-empty and no pop occurs, saturating at MAX_WAIT.
  - Clears on a pop or when the FIFO is empty.
- **force_b:** asserted when the FIFO is non-empty and the starve counter equals MAX_WAIT.
- **Grant, evaluated each cycle in priority order:**
  1. force_b: grant B head; a_ready = 0.
  2. else if a_valid: grant A; a_ready = 1.
  3. else if FIFO non-empty: grant B head; a_ready = 1.
  4. else: idle; a_ready = 1.
- **Effect of a grant at the rising edge:**
  - A grant consumes the A handshake.
  - A B grant pops the FIFO head.
  - In both cases the winning addr/data are registered onto rf_write_addr/rf_write_data.
  - rf_write_enable is registered to 0 only if the winning addr ≠ 0.
- **x0 writes** are accepted and popped normally but never assert rf_write_enable.
- **Idle cycle:** rf_write_enable is registered to 1; addr and data hold their last value.
- **busy_mask** is combinational from the valid FIFO entries. Bit 0 is always 0.
- **Ordering:** the block does not enforce ordering between A and B writes to the same register. The issue stage must stall any instruction whose rd or rs hits busy_mask.
- **Simultaneous push and pop:** legal when not full. Occupancy is unchanged and the pointers both advance.

## Timing
- **Reset values** (asynchronous, held while reset is 0):
  - FIFO empty, pointers 0, starve counter 0.
  - rf_write_enable = 1, rf_write_addr = 0, rf_write_data = 0.
  - busy_mask = 0, b_ready = 1, a_ready = 1.
- **Reset mid-operation:** discards all FIFO contents and any registered write. No write enable is issued after reset asserts.
- **A path:** handshake at rising edge E puts the write on the outputs after E. The register file captures it at the falling edge following E, so the result is readable half a cycle after E. Latency is one edge.
- **B path:** minimum latency is push at E, pop at E+1, written at the falling edge after E+1.
- **Worst-case B head wait** with A continuously valid is MAX_WAIT cycles, then exactly one A stall cycle.
- **a_ready** depends only on registered state (force_b). There is no combinational path from a_valid to a_ready.
- **Throughput:** one write per cycle.

## Test plan
- **Reset:** assert reset mid-cycle with 1 FIFO entry → immediately rf_write_enable = 1, busy_mask = 0, b_ready = 1. After release, no write occurs.
- **A only:** a_valid, a_addr = 5, a_data = 0xDEADBEEF → after the edge, rf_write_enable = 0, addr 5, data 0xDEADBEEF. Register 5 reads 0xDEADBEEF after the falling edge.
- **Starvation:** push B (addr 7, 0x11110007) while A is valid every cycle → B is held for 4 cycles with busy_mask[7] = 1. On cycle 5, a_ready = 0 and the 0x11110007 write to register 7 occurs. busy_mask[7] clears and a_ready returns to 1.
- **FIFO full:** with A saturating, push B to addr 3 and then addr 9 → b_ready = 0 and busy_mask = 0x208. A third b_valid is not accepted until after the first pop.
- **x0:** an A write to addr 0 with data 0xFFFFFFFF → a_ready = 1 and rf_write_enable stays 1. Register 0 still reads 0.
- **Same-cycle push and pop:** FIFO holds 1 entry, A idle, b_valid → the head is written, the new entry is stored, and occupancy stays 1.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter_if
//  Description : Bundles the two writeback sources (A: execute/ALU, B:
//                load/CSR), the register-file write port and the pending-write
//                mask into one interface.
//                  master : the core side (drives sources, observes the RF
//                           port and busy mask)
//                  slave  : the arbiter
//  Ports       : a_valid/a_ready/a_addr/a_data   - A source handshake
//                b_valid/b_ready/b_addr/b_data   - B source handshake
//                rf_write_enable (active-low), rf_write_addr, rf_write_data
//                busy_mask                       - registers with pending B writes
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;

    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;

    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;

    logic [31:0] busy_mask;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  rf_write_enable, rf_write_addr, rf_write_data,
        input  busy_mask
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output rf_write_enable, rf_write_addr, rf_write_data,
        output busy_mask
    );
endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Shares the single register-file write port between a
//                fixed-latency, high-priority, unbuffered source A and a
//                variable-latency source B buffered in a DEPTH-entry FIFO.
//                A starvation guard forces the B head to win once it has
//                waited MAX_WAIT cycles. busy_mask flags every register that
//                has a write pending in the FIFO.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous, active-low
//                bus   - writeback_arbiter_if.slave (sources, RF port, mask)
//  Parameters  : DEPTH    - B FIFO entries (power of two, >= 2)
//                MAX_WAIT - cycles the B head may wait before forcing (>= 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  wire                  clk,
    input  wire                  reset,
    writeback_arbiter_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);
    localparam logic [SW-1:0]    c_MAX_WAIT = SW'(MAX_WAIT);
    localparam logic [SW-1:0]    c_SW_ONE   = SW'(1);

    // FIFO storage (no reset needed: r_entry_valid qualifies every entry)
    logic [4:0]        r_fifo_addr [DEPTH];
    logic [31:0]       r_fifo_data [DEPTH];

    logic [DEPTH-1:0]  r_entry_valid;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [SW-1:0]     r_starve;

    logic              r_we_n;
    logic [4:0]        r_wr_addr;
    logic [31:0]       r_wr_data;

    logic              w_empty;
    logic              w_full;
    logic              w_force_b;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_push;
    logic              w_pop;
    logic [4:0]        w_win_addr;
    logic [31:0]       w_win_data;
    logic [31:0]       w_busy;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);

    // Forcing is derived only from registered state, so a_ready never
    // depends combinationally on a_valid.
    assign w_force_b = !w_empty && (r_starve == c_MAX_WAIT);

    assign w_grant_a = !w_force_b && bus.a_valid;
    assign w_grant_b = w_force_b || (!bus.a_valid && !w_empty);

    assign w_pop     = w_grant_b;
    // Push refused while full even if a pop happens in the same cycle.
    assign w_push    = bus.b_valid && !w_full;

    assign w_win_addr = w_grant_a ? bus.a_addr : r_fifo_addr[r_rd_ptr];
    assign w_win_data = w_grant_a ? bus.a_data : r_fifo_data[r_rd_ptr];

    assign bus.a_ready         = !w_force_b;
    assign bus.b_ready         = !w_full;
    assign bus.rf_write_enable = r_we_n;
    assign bus.rf_write_addr   = r_wr_addr;
    assign bus.rf_write_data   = r_wr_data;
    assign bus.busy_mask       = w_busy;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_entry_valid[i]) begin
                w_busy[r_fifo_addr[i]] = 1'b1;
            end
        end
        // x0 is never written, so it never needs to stall issue.
        w_busy[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.b_addr;
            r_fifo_data[r_wr_ptr] <= bus.b_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_entry_valid <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_starve      <= '0;
        end else begin
            // Pointers only coincide when empty (no pop) or full (no push),
            // so the clear and set below never target the same entry.
            if (w_pop) begin
                r_entry_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr                <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push) begin
                r_entry_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr                <= r_wr_ptr + c_PTR_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (r_starve != c_MAX_WAIT) begin
                r_starve <= r_starve + c_SW_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we_n    <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_grant_a || w_grant_b) begin
            r_wr_addr <= w_win_addr;
            r_wr_data <= w_win_data;
            r_we_n    <= (w_win_addr == 5'd0);
        end else begin
            r_we_n    <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Directed self-checking bench for writeback_arbiter
//                (DEPTH=2, MAX_WAIT=4). A register-file model captures writes
//                on the falling edge, as the real register file does.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;

    logic clk;
    logic reset;

    writeback_arbiter_if bus ();

    writeback_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf_model [32] = '{default: 32'h0};

    always @(negedge clk) begin
        if (!bus.rf_write_enable && bus.rf_write_addr != 5'd0) begin
            rf_model[bus.rf_write_addr] <= bus.rf_write_data;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_addr  = a;
        bus.a_data  = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.b_valid = v;
        bus.b_addr  = a;
        bus.b_data  = d;
    endtask

    logic exp_ready;

    initial begin
        reset = 1'b0;
        set_a(1'b0, 5'd0, 32'h0);
        set_b(1'b0, 5'd0, 32'h0);
        step();
        step();

        // ---- reset state ----
        check("rst_we",     {31'h0, bus.rf_write_enable}, 32'h1);
        check("rst_addr",   {27'h0, bus.rf_write_addr},   32'h0);
        check("rst_data",   bus.rf_write_data,            32'h0);
        check("rst_busy",   bus.busy_mask,                32'h0);
        check("rst_bready", {31'h0, bus.b_ready},         32'h1);
        check("rst_aready", {31'h0, bus.a_ready},         32'h1);
        #2 reset = 1'b1;
        step();

        // ---- A only ----
        set_a(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        set_a(1'b0, 5'd0, 32'h0);
        check("a_we",   {31'h0, bus.rf_write_enable}, 32'h0);
        check("a_addr", {27'h0, bus.rf_write_addr},   32'd5);
        check("a_data", bus.rf_write_data,            32'hDEADBEEF);
        @(negedge clk); #1;
        check("a_rf5", rf_model[5], 32'hDEADBEEF);
        step();
        check("idle_we",   {31'h0, bus.rf_write_enable}, 32'h1);
        check("idle_addr", {27'h0, bus.rf_write_addr},   32'd5);

        // ---- starvation ----
        set_a(1'b1, 5'd1, 32'hA0A0A0A0);
        set_b(1'b1, 5'd7, 32'h11110007);
        step();
        set_b(1'b0, 5'd0, 32'h0);
        check("stv_push_busy", bus.busy_mask, 32'h80);
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_ready = (i == 4) ? 1'b0 : 1'b1;
            check($sformatf("stv_hold%0d_addr", i),  {27'h0, bus.rf_write_addr}, 32'd1);
            check($sformatf("stv_hold%0d_busy", i),  bus.busy_mask, 32'h80);
            check($sformatf("stv_hold%0d_aready", i), {31'h0, bus.a_ready}, {31'h0, exp_ready});
        end
        step();
        check("stv_we",     {31'h0, bus.rf_write_enable}, 32'h0);
        check("stv_addr",   {27'h0, bus.rf_write_addr},   32'd7);
        check("stv_data",   bus.rf_write_data,            32'h11110007);
        check("stv_busy",   bus.busy_mask,                32'h0);
        check("stv_aready", {31'h0, bus.a_ready},         32'h1);
        @(negedge clk); #1;
        check("stv_rf7", rf_model[7], 32'h11110007);
        set_a(1'b0, 5'd0, 32'h0);
        step();

        // ---- FIFO full ----
        set_a(1'b1, 5'd1, 32'hA1A1A1A1);
        set_b(1'b1, 5'd3, 32'h00000033);
        step();                                  // push 3
        set_b(1'b1, 5'd9, 32'h00000099);
        step();                                  // push 9, now full
        check("full_bready", {31'h0, bus.b_ready}, 32'h0);
        check("full_busy",   bus.busy_mask,        32'h208);
        set_b(1'b1, 5'd12, 32'h000000CC);
        step();
        check("full_refuse_busy", bus.busy_mask, 32'h208);
        step();
        step();
        check("full_force_aready", {31'h0, bus.a_ready}, 32'h0);
        check("full_force_busy",   bus.busy_mask,        32'h208);
        step();                                  // forced pop of 3, push refused
        check("full_pop_addr",   {27'h0, bus.rf_write_addr}, 32'd3);
        check("full_pop_data",   bus.rf_write_data,          32'h33);
        check("full_pop_bready", {31'h0, bus.b_ready},       32'h1);
        check("full_pop_busy",   bus.busy_mask,              32'h200);
        step();                                  // push 12 accepted, A wins
        set_b(1'b0, 5'd0, 32'h0);
        check("full_third_busy", bus.busy_mask,              32'h1200);
        check("full_third_addr", {27'h0, bus.rf_write_addr}, 32'd1);
        set_a(1'b0, 5'd0, 32'h0);
        step();
        check("drain9_addr",  {27'h0, bus.rf_write_addr}, 32'd9);
        step();
        check("drain12_addr", {27'h0, bus.rf_write_addr}, 32'd12);
        check("drain12_data", bus.rf_write_data,          32'hCC);
        step();
        check("drain_idle_we", {31'h0, bus.rf_write_enable}, 32'h1);
        check("drain_busy",    bus.busy_mask,                32'h0);

        // ---- x0 write ----
        set_a(1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check("x0_aready", {31'h0, bus.a_ready}, 32'h1);
        step();
        set_a(1'b0, 5'd0, 32'h0);
        check("x0_we", {31'h0, bus.rf_write_enable}, 32'h1);
        @(negedge clk); #1;
        check("x0_rf0", rf_model[0], 32'h0);
        step();

        // ---- simultaneous push and pop ----
        set_a(1'b1, 5'd2, 32'h22222222);
        set_b(1'b1, 5'd4, 32'h00000044);
        step();                                  // A wins, 4 pushed
        set_a(1'b0, 5'd0, 32'h0);
        set_b(1'b1, 5'd6, 32'h00000066);
        step();                                  // pop 4, push 6
        set_b(1'b0, 5'd0, 32'h0);
        check("pp_we",     {31'h0, bus.rf_write_enable}, 32'h0);
        check("pp_addr",   {27'h0, bus.rf_write_addr},   32'd4);
        check("pp_data",   bus.rf_write_data,            32'h44);
        check("pp_busy",   bus.busy_mask,                32'h40);
        check("pp_bready", {31'h0, bus.b_ready},         32'h1);
        step();
        check("pp_next_addr", {27'h0, bus.rf_write_addr}, 32'd6);
        check("pp_next_busy", bus.busy_mask,              32'h0);
        step();

        // ---- reset mid-operation ----
        set_a(1'b1, 5'd1, 32'hA2A2A2A2);
        set_b(1'b1, 5'd10, 32'h000000AA);
        step();
        set_a(1'b0, 5'd0, 32'h0);
        set_b(1'b0, 5'd0, 32'h0);
        check("mrst_pre_busy", bus.busy_mask, 32'h400);
        #2 reset = 1'b0;
        #1;
        check("mrst_we",     {31'h0, bus.rf_write_enable}, 32'h1);
        check("mrst_busy",   bus.busy_mask,                32'h0);
        check("mrst_bready", {31'h0, bus.b_ready},         32'h1);
        check("mrst_aready", {31'h0, bus.a_ready},         32'h1);
        step();
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mrst_after%0d_we", i), {31'h0, bus.rf_write_enable}, 32'h1);
        end
        check("mrst_rf10", rf_model[10], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
